// File: rtl/response_transmitter.sv
// Builds a status/command/payload/checksum response frame and feeds it to the UART TX one byte at a time.
// First tx_start 2 cycles after the request; each byte waits for tx_busy to rise and fall, aborting on timeout.
module response_transmitter #(
    parameter int          DATA_BYTES     = 4,
    parameter logic [7:0]  ACK_BYTE       = 8'hAC,
    parameter logic [7:0]  NACK_BYTE      = 8'h15,
    parameter int          TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_send_ack,
    input  logic                    i_send_nack,
    input  logic [7:0]              i_cmd_code,
    input  logic                    i_with_data,
    input  logic [8*DATA_BYTES-1:0] i_resp_data,
    input  logic                    i_tx_busy,
    output logic [7:0]              o_tx_data,
    output logic                    o_tx_start,
    output logic                    o_resp_busy,
    output logic                    o_resp_done,
    output logic                    o_resp_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT_ACCEPT,
        S_WAIT_DONE,
        S_FINISH,
        S_ERROR
    } state_t;

    localparam logic [15:0] TIMER_INIT = 16'(TIMEOUT_CYCLES);
    localparam logic [3:0]  LAST_FULL  = 4'(DATA_BYTES + 2);

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_is_nack;
    logic                    r_has_data;
    logic [7:0]              r_cmd;
    logic [8*DATA_BYTES-1:0] r_data;
    logic [3:0]              r_idx;
    logic [7:0]              r_csum;
    logic [7:0]              r_tx_data;
    logic [15:0]             r_timer;

    logic                    w_req;
    logic [3:0]              w_last_idx;
    logic [3:0]              w_idx_nxt;
    logic                    w_more;
    logic                    w_expired;

    assign w_req      = i_send_ack | i_send_nack;
    assign w_last_idx = r_has_data ? LAST_FULL : 4'd2;
    assign w_idx_nxt  = r_idx + 4'd1;
    assign w_more     = (r_idx != w_last_idx);
    // The decrement that would land on zero is the expiry edge, so each wait lasts exactly TIMEOUT_CYCLES.
    assign w_expired  = (r_timer == 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:        if (w_req) w_next = S_LOAD;
            S_LOAD:        w_next = S_SEND;
            S_SEND: begin
                if (!i_tx_busy)     w_next = S_WAIT_ACCEPT;
                else if (w_expired) w_next = S_ERROR;
            end
            S_WAIT_ACCEPT: begin
                if (i_tx_busy)      w_next = S_WAIT_DONE;
                else if (w_expired) w_next = S_ERROR;
            end
            S_WAIT_DONE: begin
                if (!i_tx_busy)     w_next = w_more ? S_SEND : S_FINISH;
                else if (w_expired) w_next = S_ERROR;
            end
            S_FINISH:      w_next = S_IDLE;
            S_ERROR:       w_next = S_IDLE;
            default:       w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_tx_start   = (r_state == S_SEND) && !i_tx_busy;
        o_resp_busy  = (r_state != S_IDLE);
        o_resp_done  = (r_state == S_FINISH);
        o_resp_error = (r_state == S_ERROR);
    end

    assign o_tx_data = r_tx_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_nack  <= 1'b0;
            r_has_data <= 1'b0;
            r_cmd      <= 8'h00;
            r_data     <= '0;
            r_idx      <= 4'd0;
            r_csum     <= 8'h00;
            r_tx_data  <= 8'h00;
            r_timer    <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_is_nack  <= i_send_nack;
                        r_has_data <= i_with_data & ~i_send_nack;
                        r_cmd      <= i_cmd_code;
                        r_data     <= i_resp_data;
                    end
                end
                S_LOAD: begin
                    r_tx_data <= r_is_nack ? NACK_BYTE : ACK_BYTE;
                    r_csum    <= 8'h00;
                    r_idx     <= 4'd0;
                    r_timer   <= TIMER_INIT;
                end
                S_SEND: begin
                    if (!i_tx_busy) begin
                        r_csum  <= r_csum ^ r_tx_data;
                        r_timer <= TIMER_INIT;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                S_WAIT_ACCEPT: begin
                    if (i_tx_busy) r_timer <= TIMER_INIT;
                    else           r_timer <= r_timer - 16'd1;
                end
                S_WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        if (w_more) begin
                            r_idx   <= w_idx_nxt;
                            r_timer <= TIMER_INIT;
                            // Payload leaves MSB-first by shifting the latched word up one byte per send.
                            if (w_idx_nxt == w_last_idx) begin
                                r_tx_data <= r_csum;
                            end else if (w_idx_nxt == 4'd1) begin
                                r_tx_data <= r_cmd;
                            end else begin
                                r_tx_data <= r_data[8*DATA_BYTES-1 -: 8];
                                r_data    <= r_data << 8;
                            end
                        end
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_response_transmitter.sv
// Randomized and directed bench for response_transmitter against a frame-level reference model and a UART busy model.
module tb_response_transmitter;

    localparam int DB = 4;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            send_ack;
    logic            send_nack;
    logic [7:0]      cmd_code;
    logic            with_data;
    logic [8*DB-1:0] resp_data;
    logic            tx_busy;
    logic [7:0]      tx_data;
    logic            tx_start;
    logic            resp_busy;
    logic            resp_done;
    logic            resp_error;

    response_transmitter #(
        .DATA_BYTES    (DB),
        .ACK_BYTE      (8'hAC),
        .NACK_BYTE     (8'h15),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_send_ack  (send_ack),
        .i_send_nack (send_nack),
        .i_cmd_code  (cmd_code),
        .i_with_data (with_data),
        .i_resp_data (resp_data),
        .i_tx_busy   (tx_busy),
        .o_tx_data   (tx_data),
        .o_tx_start  (tx_start),
        .o_resp_busy (resp_busy),
        .o_resp_done (resp_done),
        .o_resp_error(resp_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // UART model: busy for busy_len cycles after each accepted start strobe.
    int   busy_len   = 10;
    int   busy_cnt   = 0;
    logic force_busy = 1'b0;
    always @(posedge clk) begin
        if (tx_start)          busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = force_busy | (busy_cnt != 0);

    logic [7:0] rx_q[$];
    int         rx_cyc[$];
    int         done_n = 0;
    int         err_n = 0;
    int         done_cyc = 0;
    int         err_cyc = 0;
    always @(negedge clk) begin
        if (tx_start) begin
            rx_q.push_back(tx_data);
            rx_cyc.push_back(cyc);
        end
        if (resp_done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (resp_error) begin
            err_n++;
            err_cyc = cyc;
        end
    end

    int n_chk = 0;
    int n_pass = 0;
    logic [7:0] exp_q[$];

    task automatic model(input bit nack, input bit wd, input logic [7:0] cmd, input logic [8*DB-1:0] data);
        logic [7:0] x;
        exp_q.delete();
        exp_q.push_back(nack ? 8'h15 : 8'hAC);
        exp_q.push_back(cmd);
        if (!nack && wd)
            for (int k = 0; k < DB; k++) exp_q.push_back(data[8*(DB-1-k) +: 8]);
        x = 8'h00;
        foreach (exp_q[i]) x = x ^ exp_q[i];
        exp_q.push_back(x);
    endtask

    task automatic run_frame(input bit ack, input bit nack, input logic [7:0] cmd, input bit wd,
                             input logic [8*DB-1:0] data, input int blen, input int bp,
                             input int inject_at, input string name);
        int lo, d0, e0, req_cyc, t, got, exp_first;
        model(nack, wd, cmd, data);
        busy_len = blen;
        lo = rx_q.size();
        d0 = done_n;
        e0 = err_n;
        @(posedge clk); #1;
        send_ack = ack; send_nack = nack; cmd_code = cmd; with_data = wd; resp_data = data;
        force_busy = (bp > 0);
        req_cyc = cyc;
        @(posedge clk); #1;
        send_ack = 0; send_nack = 0;
        cmd_code = 8'($urandom); resp_data = {$urandom}; with_data = ~wd;
        t = 0;
        while (done_n == d0 && err_n == e0 && t < 3000) begin
            force_busy = (t + 1 < bp);
            send_ack = (t == inject_at);
            @(posedge clk); #1;
            t++;
        end
        send_ack = 0;
        force_busy = 0;
        n_chk++;
        if (done_n == d0 + 1 && err_n == e0) n_pass++;
        else $display("FAIL %s completion: done=%0d err=%0d, required done=1 err=0", name, done_n - d0, err_n - e0);
        got = rx_q.size() - lo;
        n_chk++;
        if (got == exp_q.size()) n_pass++;
        else $display("FAIL %s length: got %0d bytes, required %0d", name, got, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got; i++) begin
            n_chk++;
            if (rx_q[lo+i] === exp_q[i]) n_pass++;
            else $display("FAIL %s byte%0d: got %02h, required %02h", name, i, rx_q[lo+i], exp_q[i]);
        end
        if (got > 0) begin
            exp_first = (bp > 0) ? req_cyc + bp : req_cyc + 2;
            n_chk++;
            if (rx_cyc[lo] == exp_first) n_pass++;
            else $display("FAIL %s first_start: at cycle %0d, required %0d", name, rx_cyc[lo], exp_first);
        end
        for (int i = 1; i < got; i++) begin
            n_chk++;
            if (rx_cyc[lo+i] - rx_cyc[lo+i-1] >= blen + 1) n_pass++;
            else $display("FAIL %s gap%0d: %0d cycles, required >= %0d", name, i, rx_cyc[lo+i] - rx_cyc[lo+i-1], blen + 1);
        end
        @(negedge clk);
        n_chk++;
        if (resp_busy === 1'b0 && cyc == done_cyc + 1) n_pass++;
        else $display("FAIL %s busy_after_done: resp_busy=%b at cycle %0d, required 0 at cycle %0d", name, resp_busy, cyc, done_cyc + 1);
        if (inject_at >= 0) begin
            repeat (40) @(posedge clk);
            n_chk++;
            if (rx_q.size() - lo == exp_q.size() && done_n == d0 + 1) n_pass++;
            else $display("FAIL %s ignored_request: bytes=%0d done=%0d, required %0d and 1", name, rx_q.size() - lo, done_n - d0, exp_q.size());
        end
    endtask

    task automatic check_outputs_zero(input string name);
        n_chk++;
        if ({tx_data, tx_start, resp_busy, resp_done, resp_error} === 12'h000) n_pass++;
        else $display("FAIL %s: tx_data=%02h start=%b busy=%b done=%b err=%b, required all 0",
                      name, tx_data, tx_start, resp_busy, resp_done, resp_error);
    endtask

    task automatic test_reset();
        int lo, t, n, d0;
        rst_n = 0; send_ack = 0; send_nack = 0; cmd_code = 0; with_data = 0; resp_data = 0;
        repeat (3) @(posedge clk);
        #1 check_outputs_zero("reset_state");
        rst_n = 1;
        busy_len = 10;
        lo = rx_q.size();
        @(posedge clk); #1;
        send_ack = 1; cmd_code = 8'h30; with_data = 1; resp_data = 32'h11223344;
        @(posedge clk); #1;
        send_ack = 0;
        t = 0;
        while (rx_q.size() < lo + 2 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        n_chk++;
        if (rx_q.size() >= lo + 2) n_pass++;
        else $display("FAIL reset_prep: %0d bytes sent, required 2", rx_q.size() - lo);
        repeat (3) @(posedge clk);
        #3 rst_n = 0;
        #1 check_outputs_zero("reset_midframe");
        n = rx_q.size();
        d0 = done_n;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        repeat (30) @(posedge clk);
        n_chk++;
        if (rx_q.size() == n && done_n == d0) n_pass++;
        else $display("FAIL reset_dropped: %0d extra bytes, %0d done pulses, required 0", rx_q.size() - n, done_n - d0);
        run_frame(1, 0, 8'h30, 1, 32'h11223344, 10, 0, -1, "post_reset");
    endtask

    task automatic test_ack_no_data();
        run_frame(1, 0, 8'h21, 0, 32'hDEADBEEF, 10, 0, -1, "ack_nodata");
    endtask

    task automatic test_ack_data();
        run_frame(1, 0, 8'h30, 1, 32'h11223344, 10, 0, -1, "ack_data");
    endtask

    task automatic test_nack_precedence();
        run_frame(1, 1, 8'h21, 1, 32'h11223344, 10, 0, 6, "nack_prec");
    endtask

    task automatic test_timeout();
        int lo, d0, e0, t;
        model(0, 0, 8'h5A, 32'h0);
        busy_len = 1000;
        lo = rx_q.size(); d0 = done_n; e0 = err_n;
        @(posedge clk); #1;
        send_ack = 1; cmd_code = 8'h5A; with_data = 0;
        @(posedge clk); #1;
        send_ack = 0;
        t = 0;
        while (err_n == e0 && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        n_chk++;
        if (err_n == e0 + 1 && done_n == d0) n_pass++;
        else $display("FAIL timeout_pulse: err=%0d done=%0d, required 1 and 0", err_n - e0, done_n - d0);
        n_chk++;
        if (rx_q.size() - lo == 1 && rx_q[lo] === exp_q[0]) n_pass++;
        else $display("FAIL timeout_bytes: %0d bytes sent, required 1 byte %02h", rx_q.size() - lo, exp_q[0]);
        if (rx_q.size() > lo) begin
            n_chk++;
            if (err_cyc - rx_cyc[lo] == TO + 2) n_pass++;
            else $display("FAIL timeout_delay: %0d cycles after start, required %0d", err_cyc - rx_cyc[lo], TO + 2);
        end
        @(negedge clk);
        n_chk++;
        if (resp_busy === 1'b0) n_pass++;
        else $display("FAIL timeout_busy: resp_busy=%b, required 0", resp_busy);
        t = 0;
        while (busy_cnt != 0 && t < 1500) begin
            @(posedge clk);
            t++;
        end
        run_frame(1, 0, 8'h66, 1, 32'hCAFEF00D, 10, 0, -1, "after_timeout");
    endtask

    task automatic test_backpressure();
        run_frame(1, 0, 8'h30, 1, 32'h11223344, 10, 5, -1, "backpressure");
    endtask

    task automatic test_random();
        int sel;
        for (int i = 0; i < 20; i++) begin
            sel = $urandom_range(0, 2);
            run_frame(sel != 1, sel != 0, 8'($urandom), 1'($urandom), {$urandom},
                      $urandom_range(1, 12), 0, -1, $sformatf("random%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_ack_no_data();
        test_ack_data();
        test_nack_precedence();
        test_timeout();
        test_backpressure();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/response_transmitter.md
Name: response_transmitter

Overview:
- Transmit-side counterpart of the command-receive controller.
- When the receive controller asks for a response (ACK after a completed memory access, or NACK on a rejected command), this block builds a framed response and hands it byte by byte to the UART TX through a start/busy handshake.
- Frame order: status byte, echoed command, optional payload, XOR checksum.
- It sits between the communication controller / memory read path and the UART transmitter.

Parameters:
- DATA_BYTES, 4, number of payload bytes appended on an ACK with data (1..8).
- ACK_BYTE, 8'hAC, status byte sent for an acknowledge.
- NACK_BYTE, 8'h15, status byte sent for a negative acknowledge.
- TIMEOUT_CYCLES, 65535, maximum cycles allowed per byte handshake phase before the frame is aborted (2..65535).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- send_ack  input  1  single-cycle request: send an ACK frame
- send_nack  input  1  single-cycle request: send a NACK frame
- cmd_code  input  8  command to echo; sampled on the request cycle
- with_data  input  1  include payload (ACK only); sampled on the request cycle
- resp_data  input  8*DATA_BYTES  payload, MSB byte sent first; sampled on the request cycle
- tx_busy  input  1  UART TX busy flag
- tx_data  output  8  byte to transmit; valid while tx_start=1
- tx_start  output  1  single-cycle UART start strobe
- resp_busy  output  1  high from the accepted request until the frame ends
- resp_done  output  1  single-cycle pulse after the last byte has completed
- resp_error  output  1  single-cycle pulse on a handshake timeout

Behaviour:
- Reset (asynchronous, any state): FSM to IDLE; tx_data=0, tx_start=0, resp_busy=0, resp_done=0, resp_error=0; byte index, checksum and timer cleared. A frame in progress is dropped with no further tx_start.
- States: IDLE, LOAD, SEND, WAIT_ACCEPT, WAIT_DONE, FINISH, ERROR.
- IDLE:
  - On send_ack|send_nack, latch cmd_code, resp_data and with_data, then go to LOAD.
  - send_nack wins if both requests are high.
  - Requests arriving while not in IDLE are ignored; there is no queue.
- LOAD: build the frame and clear the checksum.
  - byte0 = NACK_BYTE if NACK, else ACK_BYTE.
  - byte1 = cmd_code.
  - Payload bytes only if ACK and with_data; with_data is ignored on a NACK.
  - Last byte = XOR of all preceding bytes.
  - Frame length is 3 bytes, or 3+DATA_BYTES with payload.
- SEND:
  - When tx_busy=0, drive tx_data=current byte with tx_start=1 for exactly one cycle, fold the byte into the checksum, load the timer, and go to WAIT_ACCEPT.
  - While tx_busy=1, hold in SEND with the timer running.
- WAIT_ACCEPT: wait for tx_busy=1, then reload the timer and go to WAIT_DONE.
- WAIT_DONE:
  - Wait for tx_busy=0.
  - If more bytes remain, increment the index and go to SEND.
  - Otherwise go to FINISH.
- FINISH: pulse resp_done for one cycle, then go to IDLE.
- ERROR: entered when the timer expires in SEND, WAIT_ACCEPT or WAIT_DONE. Pulse resp_error for one cycle, then go to IDLE. resp_done is not pulsed.
- Timer: 16-bit down-counter loaded with TIMEOUT_CYCLES on entry to each waiting state; expiry is when it reaches 0.
- resp_busy: high in every state except IDLE; it drops on the cycle after the resp_done or resp_error pulse.
- Latency: the first tx_start occurs 2 cycles after the request cycle when tx_busy=0.
- Byte timing: consecutive tx_start strobes are separated by at least the UART busy period plus 1 cycle.
- tx_data holds its last value when idle; it is only meaningful while tx_start=1.

Test Plan:
- Reset: assert rst_n=0 mid-frame (after byte 1) → all outputs 0 within the same cycle, no further tx_start, and a new request after release sends a full frame.
- ACK without data: send_ack, cmd_code=0x21, with_data=0, UART model busy 10 cycles per byte → bytes AC,21,8D; one resp_done pulse; resp_busy low on the following cycle.
- ACK with data: cmd_code=0x30, with_data=1, resp_data=0x11223344 → bytes AC,30,11,22,33,44,D8.
- NACK precedence: send_ack=send_nack=1, cmd_code=0x21, with_data=1 → bytes 15,21,34 with no payload; a second send_ack during the frame is ignored, so exactly one frame is sent.
- Timeout: TIMEOUT_CYCLES=16, tx_busy stuck at 1 after byte0 is accepted → resp_error pulses 16 cycles after entering WAIT_DONE; no resp_done; back in IDLE and able to send the next frame.
- Backpressure: tx_busy=1 when the request arrives, released after 5 cycles → first tx_start on the cycle tx_busy is seen low, and the frame content is unchanged.
